wts_timer_bank: RTL and testbench
=================================

Name: wts_timer_bank

Overview:
- Parametrised interval-timer bank for the wave-table sound core on the OCM slot bus.
- Generalises the fixed two-timer, 6-bit-period scheme to NUM_TIMERS independent timers with COUNT_WIDTH-bit periods.
- Each timer has its own prescaler, one-shot/periodic mode and interrupt enable.
- Expired-and-enabled timers drive a shared active-low interrupt nint.

Parameters:
- NUM_TIMERS, 2, number of timers (1..16).
- COUNT_WIDTH, 16, period/counter width in bits (1..16).
- PRESCALE, 256, clk21m cycles per timer tick (>=2).

Ports:
- clk21m  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle bus request.
- ack  out  1  bus acknowledge, one-cycle pulse.
- wrt  in  1  1=write, 0=read; sampled with req.
- adr  in  $clog2(NUM_TIMERS)+2  register address.
- dbo  in  8  write data from CPU.
- dbi  out  8  read data to CPU, valid while ack=1.
- nint  out  1  active-low interrupt.
- timer_hit  out  NUM_TIMERS  one-cycle pulse per expiry.

Behaviour:
- Register map, timer i, base 4*i:
  - +0 CTRL (R/W): bit7 EN, bit6 ONESHOT, bit5 IE; other bits read 0.
  - +1 STATUS (RO): bit7 = ~EN, bit0 = FLAG; other bits 0. A read clears FLAG. Writes are ignored.
  - +2 PERIOD[7:0] (R/W).
  - +3 PERIOD[15:8] (R/W). Bits at or above COUNT_WIDTH are write-ignored and read 0.
- Addresses for timers >= NUM_TIMERS read 8'h00; writes to them are ignored.
- Bus handshake:
  - req is sampled at a rising edge.
  - ack=1 exactly one cycle later, with dbi registered in the same cycle.
  - dbi=0 whenever ack=0.
  - A req while ack=1 is accepted normally (back-to-back allowed).
- CTRL write, effective the cycle after the req edge:
  - counter <= PERIOD.
  - prescaler <= 0.
  - FLAG is left unchanged.
- Prescaler: counts 0..PRESCALE-1 while EN=1 and is held at 0 while EN=0. A tick occurs when it wraps to 0.
- On a tick with EN=1:
  - If counter==0: expire. Set FLAG, pulse timer_hit[i]. If ONESHOT, clear EN; else counter <= PERIOD.
  - Otherwise, counter decrements by 1.
- Expiry latency:
  - First expiry occurs (PERIOD+1)*PRESCALE cycles after the CTRL write takes effect.
  - In periodic mode, the interval between expiries is also (PERIOD+1)*PRESCALE.
  - PERIOD=0 gives an expiry every tick.
- Writing PERIOD while running does not affect the current count; the new value is used at the next reload.
- nint is registered: nint <= ~|(FLAG & IE) over all timers, so it updates one cycle after FLAG/IE changes.
- Simultaneous events:
  - Expiry and STATUS read of the same timer in the same cycle: the set wins, FLAG stays 1, and the read returns the pre-set value.
  - CTRL write and tick in the same cycle: the write wins, the counter reloads, and no expiry occurs.
- Reset, asynchronous and at any time, including mid-count:
  - All CTRL, PERIOD, FLAG, counters and prescalers go to 0.
  - Outputs: ack=0, dbi=8'h00, nint=1, timer_hit=0.

Test Plan:
- Reset: after reset release, nint=1. Read STATUS 0 -> 8'h80. Read CTRL 0 -> 8'h00. ack arrives exactly one cycle after req.
- One-shot, PRESCALE=4:
  - Stimulus: PERIOD0=3, then CTRL0=8'hE0.
  - timer_hit[0] pulses once, 16 cycles after the write takes effect.
  - nint goes low one cycle after that.
  - STATUS0 reads 8'h81, then 8'h80; nint returns to 1.
- Periodic: PERIOD1=1, CTRL1=8'hA0 (PRESCALE=4) -> timer_hit[1] pulses every 8 cycles over 5 intervals. EN stays 1.
- IE masking: CTRL0=8'hC0 with PERIOD0=0 -> FLAG sets at 4 cycles and nint stays 1. A later write of CTRL0=8'h20 (IE only, EN=0) -> nint goes to 0 with no new expiry.
- Collision:
  - A STATUS read issued on the expiry cycle returns bit0=0 and FLAG remains 1; the next read returns bit0=1.
  - A CTRL rewrite on a tick cycle suppresses that expiry.
- Reset mid-count: assert reset halfway through a PERIOD=100 count -> all outputs return to reset values immediately. No timer_hit occurs after release until CTRL is rewritten.

Source files
------------

// File: rtl/wts_timer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wts_timer_bank : bank of prescaled one-shot/periodic interval timers with   |
// |                  shared active-low interrupt on the OCM slot bus.           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wts_timer_bank #(
  parameter int NUM_TIMERS  = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int PRESCALE    = 256
) (
  input  logic                          clk21m,
  input  logic                          reset,
  input  logic                          req,
  output logic                          ack,
  input  logic                          wrt,
  input  logic [$clog2(NUM_TIMERS)+1:0] adr,
  input  logic [7:0]                    dbo,
  output logic [7:0]                    dbi,
  output logic                          nint,
  output logic [NUM_TIMERS-1:0]         timer_hit
);

  localparam int              c_aw      = $clog2(NUM_TIMERS) + 2;
  localparam int              c_pw      = $clog2(PRESCALE);
  localparam logic [c_pw-1:0] c_pre_max = c_pw'(PRESCALE - 1);

  logic [c_aw-1:0]       w_tidx;
  logic [1:0]            w_off;
  logic [NUM_TIMERS-1:0] w_en;
  logic [NUM_TIMERS-1:0] w_ie;
  logic [NUM_TIMERS-1:0] w_flag;
  logic [NUM_TIMERS-1:0] w_hit;
  logic [7:0]            w_rdata [NUM_TIMERS];
  logic [7:0]            w_rd;

  logic                  r_ack;
  logic [7:0]            r_dbi;
  logic                  r_nint;

  assign w_tidx = adr >> 2;
  assign w_off  = adr[1:0];

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
    logic                   r_en;
    logic                   r_oneshot;
    logic                   r_ie;
    logic                   r_flag;
    logic                   r_hit;
    logic [COUNT_WIDTH-1:0] r_period;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [c_pw-1:0]        r_pre;

    logic        w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_plo;
    logic        w_wr_phi;
    logic        w_rd_stat;
    logic        w_tick;
    logic        w_expire;
    logic [15:0] w_per16;
    logic [15:0] w_pwr;

    assign w_sel     = req && (w_tidx == c_aw'(gi));
    assign w_wr_ctrl = w_sel && wrt && (w_off == 2'd0);
    assign w_wr_plo  = w_sel && wrt && (w_off == 2'd2);
    assign w_wr_phi  = w_sel && wrt && (w_off == 2'd3);
    assign w_rd_stat = w_sel && !wrt && (w_off == 2'd1);

    assign w_tick   = r_en && (r_pre == c_pre_max);
    // A CTRL write on the same edge restarts the count, so it masks the expiry.
    assign w_expire = w_tick && !w_wr_ctrl && (r_cnt == '0);
    assign w_per16  = 16'(r_period);

    always_comb begin
      w_pwr = w_per16;
      if (w_off == 2'd2) begin
        w_pwr[7:0] = dbo;
      end else begin
        w_pwr[15:8] = dbo;
      end
    end

    always_comb begin
      w_rdata[gi] = 8'h00;
      if (w_sel) begin
        case (w_off)
          2'd0:    w_rdata[gi] = {r_en, r_oneshot, r_ie, 5'b00000};
          2'd1:    w_rdata[gi] = {~r_en, 6'b000000, r_flag};
          2'd2:    w_rdata[gi] = w_per16[7:0];
          default: w_rdata[gi] = w_per16[15:8];
        endcase
      end
    end

    always_ff @(posedge clk21m or posedge reset) begin
      if (reset) begin
        r_en      <= 1'b0;
        r_oneshot <= 1'b0;
        r_ie      <= 1'b0;
        r_flag    <= 1'b0;
        r_hit     <= 1'b0;
        r_period  <= '0;
        r_cnt     <= '0;
        r_pre     <= '0;
      end else begin
        r_hit <= w_expire;
        if (w_wr_ctrl) begin
          r_en      <= dbo[7];
          r_oneshot <= dbo[6];
          r_ie      <= dbo[5];
          r_cnt     <= r_period;
          r_pre     <= '0;
        end else begin
          if (!r_en || w_tick) begin
            r_pre <= '0;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
          if (w_tick) begin
            if (r_cnt == '0) begin
              if (r_oneshot) begin
                r_en <= 1'b0;
              end else begin
                r_cnt <= r_period;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        if (w_expire) begin
          r_flag <= 1'b1;
        end else if (w_rd_stat) begin
          r_flag <= 1'b0;
        end
        if (w_wr_plo || w_wr_phi) begin
          r_period <= w_pwr[COUNT_WIDTH-1:0];
        end
      end
    end

    assign w_en[gi]   = r_en;
    assign w_ie[gi]   = r_ie;
    assign w_flag[gi] = r_flag;
    assign w_hit[gi]  = r_hit;
  end

  always_comb begin
    w_rd = 8'h00;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_rd = w_rd | w_rdata[i];
    end
  end

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_dbi  <= 8'h00;
      r_nint <= 1'b1;
    end else begin
      r_ack  <= req;
      r_dbi  <= (req && !wrt) ? w_rd : 8'h00;
      r_nint <= ~|(w_flag & w_ie);
    end
  end

  assign ack       = r_ack;
  assign dbi       = r_dbi;
  assign nint      = r_nint;
  assign timer_hit = w_hit;

endmodule
`default_nettype wire

// File: tb/tb_wts_timer_bank.sv
`default_nettype none
// tb_wts_timer_bank: directed stimulus checked against a timeline model of the timer bank.
module tb_wts_timer_bank;

  localparam int          NT   = 3;
  localparam int          CW   = 12;
  localparam int          P    = 4;
  localparam logic [15:0] MASK = 16'h0FFF;

  logic          clk21m = 1'b0;
  logic          reset  = 1'b1;
  logic          req    = 1'b0;
  logic          wrt    = 1'b0;
  logic [3:0]    adr    = 4'd0;
  logic [7:0]    dbo    = 8'h00;
  logic          ack;
  logic [7:0]    dbi;
  logic          nint;
  logic [NT-1:0] timer_hit;

  int checks = 0;
  int errors = 0;

  always #5 clk21m = ~clk21m;

  wts_timer_bank #(
    .NUM_TIMERS (NT),
    .COUNT_WIDTH(CW),
    .PRESCALE   (P)
  ) dut (
    .clk21m   (clk21m),
    .reset    (reset),
    .req      (req),
    .ack      (ack),
    .wrt      (wrt),
    .adr      (adr),
    .dbo      (dbo),
    .dbi      (dbi),
    .nint     (nint),
    .timer_hit(timer_hit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each running timer is described by the absolute cycle of its next expiry.
  longint     cyc = 0;
  logic       m_en   [NT];
  logic       m_os   [NT];
  logic       m_ie   [NT];
  logic       m_flag [NT];
  logic [15:0] m_per [NT];
  longint     m_next [NT];
  logic       m_ack;
  logic [7:0] m_dbi;
  logic       m_nint;
  logic [NT-1:0] m_hit;

  always @(posedge clk21m) cyc <= cyc + 1;

  function automatic bit f_sel(int i, int o);
    return req && ((int'(adr) >> 2) == i) && (int'(adr[1:0]) == o);
  endfunction

  function automatic bit f_wsel(int i, int o);
    return wrt && f_sel(i, o);
  endfunction

  function automatic bit f_exp(int i);
    return m_en[i] && (cyc == m_next[i]) && !f_wsel(i, 0);
  endfunction

  function automatic logic [7:0] f_rd();
    int t = int'(adr) >> 2;
    if (t >= NT) return 8'h00;
    case (adr[1:0])
      2'd0:    return {m_en[t], m_os[t], m_ie[t], 5'b00000};
      2'd1:    return {~m_en[t], 6'b000000, m_flag[t]};
      2'd2:    return m_per[t][7:0];
      default: return m_per[t][15:8];
    endcase
  endfunction

  function automatic bit f_irq();
    bit r = 1'b0;
    for (int i = 0; i < NT; i++) r = r | (m_flag[i] & m_ie[i]);
    return r;
  endfunction

  always @(posedge clk21m or posedge reset) begin
    if (reset) begin
      m_ack  <= 1'b0;
      m_dbi  <= 8'h00;
      m_nint <= 1'b1;
      m_hit  <= '0;
      for (int i = 0; i < NT; i++) begin
        m_en[i]   <= 1'b0;
        m_os[i]   <= 1'b0;
        m_ie[i]   <= 1'b0;
        m_flag[i] <= 1'b0;
        m_per[i]  <= 16'h0000;
        m_next[i] <= 0;
      end
    end else begin
      m_ack  <= req;
      m_dbi  <= (req && !wrt) ? f_rd() : 8'h00;
      m_nint <= !f_irq();
      for (int i = 0; i < NT; i++) begin
        m_hit[i] <= f_exp(i);
        if (f_wsel(i, 0)) begin
          m_en[i]   <= dbo[7];
          m_os[i]   <= dbo[6];
          m_ie[i]   <= dbo[5];
          m_next[i] <= cyc + (longint'(m_per[i]) + 1) * P;
        end else if (f_exp(i)) begin
          m_flag[i] <= 1'b1;
          if (m_os[i]) m_en[i] <= 1'b0;
          else m_next[i] <= cyc + (longint'(m_per[i]) + 1) * P;
        end
        if (!f_exp(i) && !wrt && f_sel(i, 1)) m_flag[i] <= 1'b0;
        if (f_wsel(i, 2)) m_per[i] <= {m_per[i][15:8], dbo} & MASK;
        if (f_wsel(i, 3)) m_per[i] <= {dbo, m_per[i][7:0]} & MASK;
      end
    end
  end

  always @(negedge clk21m) begin
    if (!reset) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("dbi", 32'(dbi), 32'(m_dbi));
      chk("nint", 32'(nint), 32'(m_nint));
      chk("timer_hit", 32'(timer_hit), 32'(m_hit));
    end
  end

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk21m);
    req = 1'b1; wrt = 1'b1; adr = a; dbo = d;
    @(negedge clk21m);
    req = 1'b0; wrt = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk21m);
    req = 1'b1; wrt = 1'b0; adr = a;
    @(negedge clk21m);
    req = 1'b0;
    d = dbi;
    chk("rd_ack", 32'(ack), 32'd1);
  endtask

  task automatic wait_hit(input int i, input int bound, output int k);
    k = 0;
    do begin
      @(negedge clk21m);
      k++;
    end while (!timer_hit[i] && k < bound);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nint"}, 32'(nint), 32'd1);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_dbi"}, 32'(dbi), 32'd0);
    chk({tag, "_hit"}, 32'(timer_hit), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int         k;
    int         hits;

    repeat (3) @(negedge clk21m);
    chk_reset_outputs("rst");
    reset = 1'b0;

    bus_rd(4'd1, d);  chk("stat0_reset", 32'(d), 32'h80);
    bus_rd(4'd0, d);  chk("ctrl0_reset", 32'(d), 32'h00);
    bus_wr(4'd12, 8'hE0);
    bus_rd(4'd12, d); chk("unmapped_rd", 32'(d), 32'h00);
    bus_wr(4'd3, 8'hFF);
    bus_rd(4'd3, d);  chk("period_hi_mask", 32'(d), 32'h0F);
    bus_wr(4'd3, 8'h00);

    // One-shot, PERIOD=3
    bus_wr(4'd2, 8'd3);
    bus_wr(4'd0, 8'hE0);
    wait_hit(0, 100, k); chk("oneshot_latency", 32'(k), 32'd16);
    @(negedge clk21m);
    chk("oneshot_nint_low", 32'(nint), 32'd0);
    chk("oneshot_single_pulse", 32'(timer_hit[0]), 32'd0);
    bus_rd(4'd1, d); chk("oneshot_stat_set", 32'(d), 32'h81);
    bus_rd(4'd1, d); chk("oneshot_stat_clr", 32'(d), 32'h80);
    chk("oneshot_nint_release", 32'(nint), 32'd1);
    bus_rd(4'd0, d); chk("oneshot_en_cleared", 32'(d), 32'h60);

    // Periodic on timer 1, PERIOD=1
    bus_wr(4'd6, 8'd1);
    bus_wr(4'd4, 8'hA0);
    wait_hit(1, 100, k); chk("periodic_first", 32'(k), 32'd8);
    for (int n = 0; n < 5; n++) begin
      wait_hit(1, 100, k); chk("periodic_interval", 32'(k), 32'd8);
    end
    bus_rd(4'd4, d); chk("periodic_en_kept", 32'(d), 32'hA0);
    bus_wr(4'd4, 8'h00);
    bus_rd(4'd5, d); chk("periodic_stat", 32'(d), 32'h81);

    // IE masking, PERIOD=0
    bus_wr(4'd2, 8'd0);
    bus_wr(4'd0, 8'hC0);
    wait_hit(0, 100, k); chk("ie_latency", 32'(k), 32'd4);
    repeat (2) @(negedge clk21m);
    chk("ie_masked_nint", 32'(nint), 32'd1);
    bus_wr(4'd0, 8'h20);
    @(negedge clk21m);
    chk("ie_unmasked_nint", 32'(nint), 32'd0);
    bus_rd(4'd1, d); chk("ie_stat", 32'(d), 32'h81);
    @(negedge clk21m);
    chk("ie_nint_release", 32'(nint), 32'd1);
    bus_wr(4'd0, 8'h00);

    // Collisions: read on expiry edge, then CTRL rewrite on expiry edge
    bus_wr(4'd2, 8'd1);
    bus_wr(4'd0, 8'hA0);
    repeat (6) @(negedge clk21m);
    bus_rd(4'd1, d);
    chk("coll_read_preset", 32'(d), 32'h00);
    chk("coll_read_hit", 32'(timer_hit[0]), 32'd1);
    bus_rd(4'd1, d); chk("coll_flag_kept", 32'(d), 32'h01);
    repeat (4) @(negedge clk21m);
    bus_wr(4'd0, 8'hA0);
    chk("coll_write_nohit", 32'(timer_hit[0]), 32'd0);
    wait_hit(0, 100, k); chk("coll_write_reload", 32'(k), 32'd8);
    bus_wr(4'd0, 8'h00);
    bus_rd(4'd1, d); chk("coll_stat_final", 32'(d), 32'h81);

    // Reset mid-count
    bus_wr(4'd4, 8'hE0);
    bus_wr(4'd2, 8'd100);
    bus_wr(4'd0, 8'hE0);
    repeat (200) @(negedge clk21m);
    chk("midcount_nint_low", 32'(nint), 32'd0);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk21m);
    reset = 1'b0;
    hits = 0;
    repeat (500) begin
      @(negedge clk21m);
      if (timer_hit != '0) hits++;
    end
    chk("post_reset_no_hit", 32'(hits), 32'd0);
    bus_rd(4'd0, d); chk("post_reset_ctrl", 32'(d), 32'h00);
    bus_rd(4'd2, d); chk("post_reset_period", 32'(d), 32'h00);

    repeat (2) @(negedge clk21m);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
